// File: rtl/des_pkg.sv
// Shared constants for the dice selector: faces table, largest face and FSM states.
package des_pkg;
  localparam int MAX_FACE = 100;
  localparam logic [6:0] FACES [8] = '{7'd2, 7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'(MAX_FACE)};
  typedef enum logic {SEL_TYPE = 1'b0, SEL_QTE = 1'b1} state_e;
endpackage

// File: rtl/front_bouton.sv
// Button front end: 2-flop synchroniser, rising-edge step pulse and, when REPEAT_EN
// is set, a hold-to-repeat counter.
module front_bouton #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);
  logic s1_q, s1_d, s2_q, s2_d, hist_q, hist_d, armed_q;
  logic edge_p, rpt_step;

  // First clock after reset preloads the whole chain, so a button held through reset never steps.
  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    hist_d = s2_q;
    if (!armed_q) begin
      s1_d   = btn;
      s2_d   = btn;
      hist_d = btn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      hist_q  <= hist_d;
      armed_q <= 1'b1;
    end
  end

  assign edge_p = s2_q & ~hist_q;
  assign step   = edge_p | rpt_step;

  if (REPEAT_EN) begin : g_rpt
    localparam int CW = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic act_q, act_d, ph_q, ph_d;

    // ph_q=0: waiting out the initial hold; ph_q=1: periodic repeat.
    always_comb begin
      cnt_d    = cnt_q;
      act_d    = act_q;
      ph_d     = ph_q;
      rpt_step = 1'b0;
      if (edge_p) begin
        act_d = 1'b1;
        ph_d  = 1'b0;
        cnt_d = CW'(1);
      end else if (act_q && s2_q) begin
        if (!ph_q && cnt_q == CW'(HOLD_CYCLES)) begin
          rpt_step = 1'b1;
          ph_d     = 1'b1;
          cnt_d    = CW'(1);
        end else if (ph_q && cnt_q == CW'(REPEAT_CYCLES)) begin
          rpt_step = 1'b1;
          cnt_d    = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        act_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        act_q <= 1'b0;
        ph_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
        ph_q  <= ph_d;
      end
    end
  end else begin : g_norpt
    assign rpt_step = 1'b0;
  end
endmodule

// File: rtl/selection_des.sv
// Dice-roll selector: buttons pick die type / dice count, outputs registered roll bounds.
// Define SELECTION_DES_AUTO_REPEAT_EN to build hold-to-repeat on suivant/precedent.
module selection_des
  import des_pkg::*;
#(
  parameter int N_TYPES       = 8,
  parameter int N_MAX         = 9,
  parameter int W             = 10,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       suivant,
  input  logic                       precedent,
  input  logic                       mode,
  output logic [$clog2(N_TYPES)-1:0] idD,
  output logic [3:0]                 nbD,
  output logic                       modeQte,
  output logic [W-1:0]               dMin,
  output logic [W-1:0]               dMax,
  output logic                       maj
);
  localparam int IW = $clog2(N_TYPES);
`ifdef SELECTION_DES_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic [2:0] btn, step;
  assign btn = {mode, precedent, suivant};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    front_bouton #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (RPT_EN && (i != 2))
    ) u_fb (
      .clk (clk),
      .rst (rst),
      .btn (btn[i]),
      .step(step[i])
    );
  end

  state_e        state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [3:0]    nb_q, nb_d;
  logic [W-1:0]  dmin_q, dmin_d, dmax_q, dmax_d;
  logic          maj_q, maj_d;
  logic [2:0]    id_ix;
  logic [10:0]   prod;

  // mode wins over steps; opposing steps in one cycle cancel.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    nb_d    = nb_q;
    if (step[2]) begin
      state_d = (state_q == SEL_TYPE) ? SEL_QTE : SEL_TYPE;
    end else if (step[0] ^ step[1]) begin
      if (state_q == SEL_TYPE) begin
        if (step[0]) id_d = (id_q == IW'(N_TYPES - 1)) ? '0 : id_q + IW'(1);
        else         id_d = (id_q == '0) ? IW'(N_TYPES - 1) : id_q - IW'(1);
      end else begin
        if (step[0]) nb_d = (nb_q == 4'(N_MAX)) ? 4'd1 : nb_q + 4'd1;
        else         nb_d = (nb_q == 4'd1) ? 4'(N_MAX) : nb_q - 4'd1;
      end
    end
  end

  // Bounds follow the registered selection one cycle later; a pair change always moves a bound.
  always_comb begin
    id_ix  = 3'(id_q);
    prod   = 11'(nb_q) * 11'(FACES[id_ix]);
    dmin_d = W'(nb_q);
    dmax_d = W'(prod);
    maj_d  = (dmin_d != dmin_q) || (dmax_d != dmax_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEL_TYPE;
      id_q    <= '0;
      nb_q    <= 4'd1;
      dmin_q  <= W'(1);
      dmax_q  <= W'(2);
      maj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      nb_q    <= nb_d;
      dmin_q  <= dmin_d;
      dmax_q  <= dmax_d;
      maj_q   <= maj_d;
    end
  end

  assign idD     = id_q;
  assign nbD     = nb_q;
  assign modeQte = (state_q == SEL_QTE);
  assign dMin    = dmin_q;
  assign dMax    = dmax_q;
  assign maj     = maj_q;
endmodule

// File: tb/tb_selection_des.sv
// Bench for selection_des: vector table, random presses against a rule-level model,
// auto-repeat and asynchronous reset sequences.
module tb_selection_des;
  localparam int NT = 8, NM = 9;
  logic clk = 1'b0, rst, suivant, precedent, mode;
  logic [2:0] idD;
  logic [3:0] nbD;
  logic       modeQte, maj;
  logic [9:0] dMin, dMax;
  int n_err = 0, n_chk = 0, maj_cnt = 0;
  int faces [8] = '{2, 4, 6, 8, 10, 12, 20, 100};

  selection_des #(.N_TYPES(NT), .N_MAX(NM), .W(10), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .suivant(suivant), .precedent(precedent), .mode(mode),
    .idD(idD), .nbD(nbD), .modeQte(modeQte), .dMin(dMin), .dMax(dMax), .maj(maj));

  always #5 clk = ~clk;
  always @(negedge clk) if (maj === 1'b1) maj_cnt++;

  typedef struct {bit s, p, m; int id, nb; bit mq;} vec_t;
  vec_t tbl [22];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, int id, int nb, int mq);
    chk({tag, " idD"}, int'(idD), id);
    chk({tag, " nbD"}, int'(nbD), nb);
    chk({tag, " modeQte"}, int'(modeQte), mq);
    chk({tag, " dMin"}, int'(dMin), nb);
    chk({tag, " dMax"}, int'(dMax), nb * faces[id]);
  endtask

  task automatic press(bit s, bit p, bit m);
    @(posedge clk); #1;
    suivant = s; precedent = p; mode = m;
    repeat (3) @(posedge clk);
    #1;
    suivant = 0; precedent = 0; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  initial begin
    int pid, pnb, m0, mid, mnb, mmq, exp_id;
    bit s, p, m;
    rst = 1; suivant = 0; precedent = 0; mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs("reset", 0, 1, 0);
    chk("reset maj", int'(maj), 0);
    rst = 0;

    tbl[0] = '{1,0,0,1,1,0};  tbl[1] = '{1,0,0,2,1,0};  tbl[2] = '{1,0,0,3,1,0};
    tbl[3] = '{0,1,0,2,1,0};  tbl[4] = '{0,1,0,1,1,0};  tbl[5] = '{0,1,0,0,1,0};
    tbl[6] = '{0,1,0,7,1,0};  tbl[7] = '{0,0,1,7,1,1};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{1, 0, 0, 7, 2 + i, 1};
    tbl[16] = '{1,0,0,7,1,1}; tbl[17] = '{0,1,0,7,9,1}; tbl[18] = '{1,1,0,7,9,1};
    tbl[19] = '{1,0,1,7,9,0}; tbl[20] = '{1,1,0,7,9,0}; tbl[21] = '{1,0,0,0,9,0};

    pid = 0; pnb = 1;
    for (int i = 0; i < 22; i++) begin
      m0 = maj_cnt;
      press(tbl[i].s, tbl[i].p, tbl[i].m);
      chk_outs($sformatf("vec%0d", i), tbl[i].id, tbl[i].nb, tbl[i].mq);
      chk($sformatf("vec%0d maj", i), maj_cnt - m0, (tbl[i].id != pid || tbl[i].nb != pnb) ? 1 : 0);
      pid = tbl[i].id; pnb = tbl[i].nb;
    end

    mid = 0; mnb = 9; mmq = 0;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1)); m = ($urandom_range(0, 3) == 0);
      pid = mid; pnb = mnb;
      if (m) mmq = 1 - mmq;
      else if (s != p) begin
        if (mmq == 0) mid = s ? (mid + 1) % NT : (mid + NT - 1) % NT;
        else          mnb = s ? mnb % NM + 1 : (mnb + NM - 2) % NM + 1;
      end
      m0 = maj_cnt;
      press(s, p, m);
      chk_outs($sformatf("rnd%0d", i), mid, mnb, mmq);
      chk($sformatf("rnd%0d maj", i), maj_cnt - m0, (mid != pid || mnb != pnb) ? 1 : 0);
    end

    do_reset();
    @(posedge clk); #1; suivant = 1;
    repeat (40) @(posedge clk);
    #1; suivant = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
`ifdef SELECTION_DES_AUTO_REPEAT_EN
    exp_id = 5;
`else
    exp_id = 1;
`endif
    chk_outs("hold40", exp_id, 1, 0);

    do_reset();
    press(0, 0, 1);
    repeat (3) press(1, 0, 0);
    press(0, 0, 1);
    repeat (5) press(1, 0, 0);
    chk_outs("setup", 5, 4, 0);
    @(posedge clk); #1; suivant = 1;
    repeat (6) @(posedge clk);
    #3 rst = 1;
    #1;
    chk_outs("async rst", 0, 1, 0);
    chk("async rst maj", int'(maj), 0);
    @(negedge clk); @(negedge clk); rst = 0;
    m0 = maj_cnt;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk_outs("held after rst", 0, 1, 0);
    chk("held after rst maj", maj_cnt - m0, 0);
    suivant = 0;
    repeat (5) @(posedge clk);
    press(1, 0, 0);
    chk_outs("after release", 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/selection_des.md
# selection_des

Parametrised dice-roll selector for the tabletop dice system: synchronous successor of the free-running die-type selector. Three buttons (`suivant`, `precedent`, `mode`) drive an FSM that selects a die type (d2…d100) and a dice count (1…N_MAX). The block outputs the registered roll bounds `dMin`/`dMax` for the whole throw, consumed by the random generator and the 7-segment display path.

## Interface
- `N_TYPES`, 8: number of selectable die types, 2..8; the first N_TYPES entries of the faces table are used.
- `N_MAX`, 9: maximum dice count, 1..15.
- `W`, 10: width of `dMin`/`dMax`; must satisfy 2^W > N_MAX*100.
- `HOLD_CYCLES`, 50_000_000: hold time before the first auto-repeat step.
- `REPEAT_CYCLES`, 12_500_000: interval between auto-repeat steps.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `suivant`  in  1  "next" button, asynchronous level, active-high.
- `precedent`  in  1  "previous" button, asynchronous level, active-high.
- `mode`  in  1  toggles between type and count selection, asynchronous level, active-high.
- `idD`  out  $clog2(N_TYPES)  selected die-type index.
- `nbD`  out  4  dice count, 1..N_MAX.
- `modeQte`  out  1  1 = count-selection state.
- `dMin`  out  W  minimum roll total, equal to nbD.
- `dMax`  out  W  maximum roll total, equal to nbD*faces(idD).
- `maj`  out  1  one-cycle pulse when `dMin`/`dMax` take a new value.

## Operation
- Faces table, by index: 2, 4, 6, 8, 10, 12, 20, 100.
- Each button goes through a 2-flop synchroniser followed by rising-edge detection. The result is a one-cycle step pulse.
- FSM states: SEL_TYPE (reset state) and SEL_QTE. A `mode` pulse toggles the state. `modeQte` = (state == SEL_QTE).
- In SEL_TYPE:
  - `suivant` pulse: idD+1, wrapping from N_TYPES-1 to 0.
  - `precedent` pulse: idD-1, wrapping from 0 to N_TYPES-1.
- In SEL_QTE:
  - `suivant` pulse: nbD+1, wrapping from N_MAX to 1.
  - `precedent` pulse: nbD-1, wrapping from 1 to N_MAX.
- Simultaneous events:
  - `suivant` and `precedent` pulses in the same cycle are both ignored.
  - A `mode` pulse has priority: any step pulse in the same cycle is dropped.
- Arithmetic: the product is computed at 11 bits (4b × 7b), then zero-extended or truncated to W. Parameter ranges guarantee there is no truncation.
- `maj` pulses only when the (idD, nbD) pair actually changed. A `mode` toggle alone produces no `maj`.
- Reset values: idD=0, nbD=1, modeQte=0, dMin=1, dMax=2, maj=0. The synchroniser, edge and repeat state are all cleared.
- Reset asserted mid-operation, including during auto-repeat, forces the reset values immediately, regardless of the clock.
- A button that is still held when reset is released does not generate a pulse: the edge-detect history resets to 1 only if the input is high at the first clock.

## Timing
- A button rising before clock edge k updates idD/nbD/modeQte at edge k+2.
- `dMin`/`dMax` update at edge k+3. `maj` is high during the cycle that follows edge k+3.
- Minimum button period for distinct steps: high 3 cycles, low 3 cycles.
- Auto-repeat (when compiled in):
  - First step on the press edge.
  - Further steps at HOLD_CYCLES after the press, then every REPEAT_CYCLES while held.
  - Release cancels the repeat at the next synchronised sample.
  - `mode` never repeats.

## Configuration
- `SELECTION_DES_AUTO_REPEAT_EN` defined: the hold-to-repeat counters are built for `suivant`/`precedent`.
- Undefined: exactly one step per press; no repeat counters are synthesised, and HOLD_CYCLES/REPEAT_CYCLES are unused.

## Structure
- Package `des_pkg` holds:
  - the faces table constant (8 × 7 bits);
  - the FSM state enum {SEL_TYPE, SEL_QTE};
  - the max-face constant 100.
- Sub-module `front_bouton`, instantiated three times: synchroniser, edge detector and optional auto-repeat counter. It is parametrised by HOLD_CYCLES/REPEAT_CYCLES and a repeat-enable parameter; `mode` instantiates it with repeat disabled.
- Top level: FSM, counters, multiplier and output registers.

## Test plan
- Reset, then 3 `suivant` presses in SEL_TYPE: idD=3, dMin=1, dMax=8, and 3 `maj` pulses.
- `precedent` from idD=0 with N_TYPES=8: idD=7, dMax=100.
- Press `mode`, then 8 `suivant` presses with idD=7 and N_MAX=9: nbD=9, dMax=900. One more press: nbD=1, dMax=100.
- `suivant`+`precedent` together, and `mode`+`suivant` together: no idD/nbD change; in the second case modeQte toggles and there is no `maj`.
- With `SELECTION_DES_AUTO_REPEAT_EN`, HOLD_CYCLES=20, REPEAT_CYCLES=5: `suivant` held 40 cycles from idD=0 gives idD=5 (1+1+3 steps).
- Assert `rst` mid-hold with idD=5, nbD=4: outputs immediately 0/1/0/1/2. A button still held after release produces no step.
